nn_layer_scheduler: RTL and testbench

- Control FSM for a multi-layer perceptron datapath with P parallel neuron lanes.
- Sequences, per layer and per group of P neurons:
  - accumulator clear;
  - K multiply-accumulate cycles, one per input index;
  - one write-back cycle.
- Generalises the single-neuron controller with lane parallelism, explicit MAC input indexing, a stall input, abort and a busy/done handshake.
- Sits between the top-level start logic and the weight/activation memories plus MAC array.

---
 rtl/nn_sched_pkg.sv | 24 ++
 rtl/nn_wrap_counter.sv | 39 +++
 rtl/nn_layer_scheduler.sv | 170 +++++++++++++++++
 tb/tb_nn_layer_scheduler.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_sched_pkg.sv
// Shared types and helpers for the layer scheduler.
// The state encoding always includes ST_BIAS. It is only reachable when
// the design is built with NN_SCHED_BIAS_EN defined.
package nn_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CLR  = 3'd1,
    ST_MAC  = 3'd2,
    ST_WR   = 3'd3,
    ST_DONE = 3'd4,
    ST_BIAS = 3'd5
  } state_e;

  // Counter width for a range of x values, never narrower than one bit
  function automatic int max1_clog2(input int x);
    if (x <= 1) begin
      return 1;
    end else begin
      return $clog2(x);
    end
  endfunction

endpackage

// File: rtl/nn_wrap_counter.sv
// Modulo-MOD counter with synchronous clear and enable.
// last flags the final count value, so callers can detect the cycle
// in which an enabled increment wraps back to zero.
module nn_wrap_counter
  import nn_sched_pkg::*;
#(
  parameter int MOD = 4,
  parameter int W   = max1_clog2(MOD)
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         last
);

  localparam logic [W-1:0] LAST_V = W'(MOD - 1);

  // Count up on en, wrap at MOD-1, clear has priority over counting
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == LAST_V) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + W'(1);
      end
    end else begin
      cnt <= cnt;
    end
  end

  assign last = (cnt == LAST_V);

endmodule

// File: rtl/nn_layer_scheduler.sv
// Control FSM for a multi-layer perceptron datapath with P neuron lanes.
// For each layer and each group of P neurons, it runs one clear cycle,
// then K MAC cycles, then one write-back cycle.
// Optional macro NN_SCHED_BIAS_EN adds a one-cycle BIAS state and a
// bias_en output between the last MAC cycle and write-back.
// Strobe outputs are registered state decodes. They are gated by abort
// (and mac_en also by stall) so that a same-cycle abort or stall
// suppresses them.
module nn_layer_scheduler
  import nn_sched_pkg::*;
#(
  parameter int M = 3,
  parameter int N = 4,
  parameter int K = 3,
  parameter int P = 2
) (
  input  logic                                clk,
  input  logic                                nrst,
  input  logic                                start,
  input  logic                                abort,
  input  logic                                stall,
  output logic                                busy,
  output logic                                acc_clr,
  output logic                                mac_en,
  output logic                                write_en,
  output logic                                done,
`ifdef NN_SCHED_BIAS_EN
  output logic                                bias_en,
`endif
  output logic [max1_clog2(M-1)-1:0]          layer_addr,
  output logic [max1_clog2((N+P-1)/P)-1:0]    group_addr,
  output logic [max1_clog2(K)-1:0]            in_addr,
  output logic [P-1:0]                        lane_valid
);

  localparam int G  = (N + P - 1) / P;
  localparam int LW = max1_clog2(M - 1);
  localparam int GW = max1_clog2(G);
  localparam int KW = max1_clog2(K);

`ifdef NN_SCHED_BIAS_EN
  localparam state_e AFTER_MAC = ST_BIAS;
`else
  localparam state_e AFTER_MAC = ST_WR;
`endif

  state_e state;
  state_e state_nxt;

  logic busy_q;
  logic clr_q;
  logic mac_q;
  logic wr_q;
  logic done_q;
`ifdef NN_SCHED_BIAS_EN
  logic bias_q;
`endif

  logic in_last;
  logic grp_last;
  logic lay_last;
  logic abort_act;
  logic in_en;
  logic grp_en;
  logic lay_en;

  // An abort only counts outside IDLE. It then clears all counters.
  assign abort_act = abort && (state != ST_IDLE);
  assign in_en     = (state == ST_MAC) && !stall && !abort_act;
  assign grp_en    = (state == ST_WR) && !abort_act;
  assign lay_en    = grp_en && grp_last;

  nn_wrap_counter #(.MOD(K), .W(KW)) u_in_cnt (
    .clk  (clk),
    .nrst (nrst),
    .en   (in_en),
    .clr  (abort_act),
    .cnt  (in_addr),
    .last (in_last)
  );

  nn_wrap_counter #(.MOD(G), .W(GW)) u_group_cnt (
    .clk  (clk),
    .nrst (nrst),
    .en   (grp_en),
    .clr  (abort_act),
    .cnt  (group_addr),
    .last (grp_last)
  );

  nn_wrap_counter #(.MOD(M - 1), .W(LW)) u_layer_cnt (
    .clk  (clk),
    .nrst (nrst),
    .en   (lay_en),
    .clr  (abort_act),
    .cnt  (layer_addr),
    .last (lay_last)
  );

  // Next-state selection: abort first, then stall-aware sequencing
  always_comb begin
    state_nxt = state;
    if (abort_act) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) state_nxt = ST_CLR;
          else       state_nxt = ST_IDLE;
        end
        ST_CLR:  state_nxt = ST_MAC;
        ST_MAC: begin
          if (!stall && in_last) state_nxt = AFTER_MAC;
          else                   state_nxt = ST_MAC;
        end
        ST_BIAS: state_nxt = ST_WR;
        ST_WR: begin
          if (grp_last && lay_last) state_nxt = ST_DONE;
          else                      state_nxt = ST_CLR;
        end
        ST_DONE: state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // State register with registered per-state strobes
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state  <= ST_IDLE;
      busy_q <= 1'b0;
      clr_q  <= 1'b0;
      mac_q  <= 1'b0;
      wr_q   <= 1'b0;
      done_q <= 1'b0;
`ifdef NN_SCHED_BIAS_EN
      bias_q <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      busy_q <= (state_nxt != ST_IDLE);
      clr_q  <= (state_nxt == ST_CLR);
      mac_q  <= (state_nxt == ST_MAC);
      wr_q   <= (state_nxt == ST_WR);
      done_q <= (state_nxt == ST_DONE);
`ifdef NN_SCHED_BIAS_EN
      bias_q <= (state_nxt == ST_BIAS);
`endif
    end
  end

  assign busy     = busy_q;
  assign acc_clr  = clr_q && !abort_act;
  assign mac_en   = mac_q && !stall && !abort_act;
  assign write_en = wr_q && !abort_act;
  assign done     = done_q && !abort_act;
`ifdef NN_SCHED_BIAS_EN
  assign bias_en  = bias_q && !abort_act;
`endif

  // Lane i is valid when its neuron index group_addr*P+i exists in the layer
  always_comb begin
    lane_valid = '0;
    for (int i = 0; i < P; i++) begin
      if ((int'(group_addr) * P + i) < N) lane_valid[i] = 1'b1;
      else                                lane_valid[i] = 1'b0;
    end
  end

endmodule

// File: tb/tb_nn_layer_scheduler.sv
// Directed self-checking bench for nn_layer_scheduler.
// Main instance uses the defaults M=3 N=4 K=3 P=2. A second instance
// with N=5 exercises the partial last group lane mask.
module tb_nn_layer_scheduler;

`ifdef NN_SCHED_BIAS_EN
  localparam int PG = 6;
`else
  localparam int PG = 5;
`endif
  localparam int LAT = 4 * PG;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic stall = 1'b0;
  logic busy, acc_clr, mac_en, write_en, done;
  logic [0:0] layer_addr;
  logic [0:0] group_addr;
  logic [1:0] in_addr;
  logic [1:0] lane_valid;
`ifdef NN_SCHED_BIAS_EN
  logic bias_en;
  logic bias5;
`endif

  logic start5 = 1'b0;
  logic zero5 = 1'b0;
  logic busy5, clr5, mac5, wr5, done5;
  logic [0:0] la5;
  logic [1:0] ga5;
  logic [1:0] ia5;
  logic [1:0] lane5;

  int n_checks = 0;
  int n_fail = 0;

  logic clr_a [0:79];
  logic mac_a [0:79];
  logic wr_a [0:79];
  logic done_a [0:79];
  logic busy_a [0:79];
  logic bias_a [0:79];
  int ia_a [0:79];
  int la_a [0:79];
  int ga_a [0:79];
  int obs_len;

  always #5 clk = ~clk;

  nn_layer_scheduler dut (
    .clk(clk), .nrst(nrst), .start(start), .abort(abort), .stall(stall),
    .busy(busy), .acc_clr(acc_clr), .mac_en(mac_en), .write_en(write_en),
    .done(done),
`ifdef NN_SCHED_BIAS_EN
    .bias_en(bias_en),
`endif
    .layer_addr(layer_addr), .group_addr(group_addr), .in_addr(in_addr),
    .lane_valid(lane_valid)
  );

  nn_layer_scheduler #(.M(3), .N(5), .K(3), .P(2)) dut5 (
    .clk(clk), .nrst(nrst), .start(start5), .abort(zero5), .stall(zero5),
    .busy(busy5), .acc_clr(clr5), .mac_en(mac5), .write_en(wr5),
    .done(done5),
`ifdef NN_SCHED_BIAS_EN
    .bias_en(bias5),
`endif
    .layer_addr(la5), .group_addr(ga5), .in_addr(ia5), .lane_valid(lane5)
  );

  // Records the main DUT's outputs cycle by cycle, starting at the CLR cycle
  // that follows a start sample. Stops at the first non-busy cycle.
  task automatic observe(input int maxc, input int st_from, input int st_len,
                         input int ab_at, input logic hold_start);
    obs_len = 0;
    for (int c = 0; c < maxc; c++) begin
      #1;
      stall = (c >= st_from) && (c < st_from + st_len);
      abort = (c == ab_at);
      start = hold_start;
      #1;
      clr_a[c] = acc_clr;  mac_a[c] = mac_en;  wr_a[c] = write_en;
      done_a[c] = done;    busy_a[c] = busy;
      ia_a[c] = int'(in_addr); la_a[c] = int'(layer_addr); ga_a[c] = int'(group_addr);
`ifdef NN_SCHED_BIAS_EN
      bias_a[c] = bias_en;
`else
      bias_a[c] = 1'b0;
`endif
      obs_len = c + 1;
      if (!busy) break;
      @(posedge clk);
    end
    stall = 1'b0;
    abort = 1'b0;
  endtask

  function automatic int find_done();
    for (int c = 0; c < obs_len; c++) if (done_a[c]) return c;
    return -1;
  endfunction

  function automatic int count_wr();
    int n = 0;
    for (int c = 0; c < obs_len; c++) if (wr_a[c]) n++;
    return n;
  endfunction

  function automatic int count_clr();
    int n = 0;
    for (int c = 0; c < obs_len; c++) if (clr_a[c]) n++;
    return n;
  endfunction

  task automatic test_reset();
    #1;
    n_checks++;
    if ({busy, acc_clr, mac_en, write_en, done} !== 5'b0) begin
      n_fail++; $display("FAIL reset_strobes: got %b expected 00000", {busy, acc_clr, mac_en, write_en, done});
    end
    n_checks++;
    if ({layer_addr, group_addr, in_addr} !== 4'b0) begin
      n_fail++; $display("FAIL reset_addr: got %b expected 0000", {layer_addr, group_addr, in_addr});
    end
    n_checks++;
    if (lane_valid !== 2'b11) begin
      n_fail++; $display("FAIL reset_lane_valid: got %b expected 11", lane_valid);
    end
    #3 nrst = 1'b1;
    abort = 1'b1;
    stall = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_ignores_abort: busy got %b expected 0", busy);
    end
    abort = 1'b0;
    stall = 1'b0;
  endtask

  task automatic test_basic_pass();
    int off, grp;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    observe(80, -1, 0, -1, 1'b0);
    for (int c = 0; c < LAT; c++) begin
      off = c % PG;
      grp = c / PG;
      n_checks++;
      if (clr_a[c] !== (off == 0) || wr_a[c] !== (off == PG - 1) ||
          mac_a[c] !== (off >= 1 && off <= 3)) begin
        n_fail++;
        $display("FAIL basic_strobes c=%0d: got clr=%b mac=%b wr=%b expected offset %0d",
                 c, clr_a[c], mac_a[c], wr_a[c], off);
      end
      n_checks++;
      if (la_a[c] != grp / 2 || ga_a[c] != grp % 2) begin
        n_fail++;
        $display("FAIL basic_addr c=%0d: got layer=%0d group=%0d expected %0d,%0d",
                 c, la_a[c], ga_a[c], grp / 2, grp % 2);
      end
      if (off >= 1 && off <= 3) begin
        n_checks++;
        if (ia_a[c] != off - 1) begin
          n_fail++; $display("FAIL basic_in_addr c=%0d: got %0d expected %0d", c, ia_a[c], off - 1);
        end
      end
    end
    n_checks++;
    if (find_done() != LAT) begin
      n_fail++; $display("FAIL basic_latency: got %0d expected %0d", find_done(), LAT);
    end
    n_checks++;
    if (count_clr() != 4 || count_wr() != 4) begin
      n_fail++; $display("FAIL basic_counts: got clr=%0d wr=%0d expected 4,4", count_clr(), count_wr());
    end
    n_checks++;
    if (obs_len != LAT + 2 || busy_a[LAT] !== 1'b1) begin
      n_fail++; $display("FAIL basic_busy_fall: got idle at %0d expected %0d", obs_len - 1, LAT + 1);
    end
  endtask

  task automatic test_lane_mask();
    logic [1:0] exp5 [0:2];
    int nw;
    int waited;
    exp5[0] = 2'b11; exp5[1] = 2'b11; exp5[2] = 2'b01;
    nw = 0;
    #1 start5 = 1'b1;
    @(posedge clk);
    #1 start5 = 1'b0;
    for (int c = 0; c < 3 * PG; c++) begin
      #1;
      if (wr5 && nw < 3) begin
        n_checks++;
        if (int'(ga5) != nw || lane5 !== exp5[nw]) begin
          n_fail++; $display("FAIL lane_mask g%0d: got group=%0d lanes=%b expected %0d,%b",
                             nw, ga5, lane5, nw, exp5[nw]);
        end
        nw++;
      end
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (nw != 3) begin
      n_fail++; $display("FAIL lane_mask_writes: got %0d expected 3", nw);
    end
    waited = 0;
    while (!done5 && waited < 100) begin
      @(posedge clk); #1; waited++;
    end
    n_checks++;
    if (waited >= 100) begin
      n_fail++; $display("FAIL lane_mask_done: got timeout expected done");
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    start = 1'b1;
    @(posedge clk);
    observe(80, 2, 4, -1, 1'b0);
    for (int c = 2; c < 6; c++) begin
      n_checks++;
      if (mac_a[c] !== 1'b0 || ia_a[c] != 1) begin
        n_fail++; $display("FAIL stall_hold c=%0d: got mac=%b in=%0d expected 0,1", c, mac_a[c], ia_a[c]);
      end
    end
    n_checks++;
    if (mac_a[6] !== 1'b1 || ia_a[6] != 1 || ia_a[7] != 2) begin
      n_fail++; $display("FAIL stall_resume: got mac=%b in=%0d,%0d expected 1,1,2", mac_a[6], ia_a[6], ia_a[7]);
    end
    n_checks++;
    if (find_done() != LAT + 4) begin
      n_fail++; $display("FAIL stall_latency: got %0d expected %0d", find_done(), LAT + 4);
    end
  endtask

  task automatic test_abort();
    int ab;
    ab = 2 * PG - 1;
    start = 1'b1;
    @(posedge clk);
    observe(80, -1, 0, ab, 1'b0);
    n_checks++;
    if (wr_a[ab] !== 1'b0 || ga_a[ab] != 1) begin
      n_fail++; $display("FAIL abort_wr: got wr=%b group=%0d expected 0,1", wr_a[ab], ga_a[ab]);
    end
    n_checks++;
    if (count_wr() != 1 || find_done() != -1) begin
      n_fail++; $display("FAIL abort_no_done: got wr=%0d done_at=%0d expected 1,-1", count_wr(), find_done());
    end
    n_checks++;
    if (obs_len != ab + 2 || la_a[ab + 1] != 0 || ga_a[ab + 1] != 0 || ia_a[ab + 1] != 0) begin
      n_fail++; $display("FAIL abort_idle: got idle at %0d addr=%0d,%0d,%0d expected %0d,0,0,0",
                         obs_len - 1, la_a[ab + 1], ga_a[ab + 1], ia_a[ab + 1], ab + 1);
    end
    start = 1'b1;
    @(posedge clk);
    observe(80, -1, 0, -1, 1'b0);
    n_checks++;
    if (find_done() != LAT || count_wr() != 4) begin
      n_fail++; $display("FAIL abort_rerun: got done_at=%0d wr=%0d expected %0d,4", find_done(), count_wr(), LAT);
    end
  endtask

  task automatic test_mid_reset();
    int r;
    r = 2 * PG + 2;
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (r) @(posedge clk);
    #1;
    n_checks++;
    if (layer_addr !== 1'b1 || mac_en !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset_pre: got layer=%b mac=%b expected 1,1", layer_addr, mac_en);
    end
    nrst = 1'b0;
    #1;
    n_checks++;
    if ({busy, acc_clr, mac_en, write_en, done, layer_addr, group_addr, in_addr} !== 9'b0) begin
      n_fail++; $display("FAIL mid_reset_zero: got %b expected 0",
                         {busy, acc_clr, mac_en, write_en, done, layer_addr, group_addr, in_addr});
    end
    #1 nrst = 1'b1;
    start = 1'b1;
    @(posedge clk);
    observe(80, -1, 0, -1, 1'b0);
    n_checks++;
    if (clr_a[0] !== 1'b1 || la_a[0] != 0 || ga_a[0] != 0 || find_done() != LAT) begin
      n_fail++; $display("FAIL mid_reset_restart: got clr=%b addr=%0d,%0d done_at=%0d expected 1,0,0,%0d",
                         clr_a[0], la_a[0], ga_a[0], find_done(), LAT);
    end
  endtask

  task automatic test_back_to_back();
    start = 1'b1;
    @(posedge clk);
    observe(80, -1, 0, -1, 1'b1);
    n_checks++;
    if (find_done() != LAT || count_clr() != 4 || obs_len != LAT + 2) begin
      n_fail++; $display("FAIL b2b_first: got done_at=%0d clr=%0d len=%0d expected %0d,4,%0d",
                         find_done(), count_clr(), obs_len, LAT, LAT + 2);
    end
`ifdef NN_SCHED_BIAS_EN
    for (int c = 1; c < obs_len; c++) begin
      if (wr_a[c]) begin
        n_checks++;
        if (bias_a[c - 1] !== 1'b1) begin
          n_fail++; $display("FAIL bias_before_wr c=%0d: got %b expected 1", c, bias_a[c - 1]);
        end
      end
    end
`endif
    @(posedge clk);
    observe(80, -1, 0, -1, 1'b1);
    n_checks++;
    if (clr_a[0] !== 1'b1 || find_done() != LAT || count_wr() != 4) begin
      n_fail++; $display("FAIL b2b_second: got clr=%b done_at=%0d wr=%0d expected 1,%0d,4",
                         clr_a[0], find_done(), count_wr(), LAT);
    end
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL b2b_stop: got busy=%b expected 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic_pass();
    test_lane_mask();
    test_stall();
    test_abort();
    test_mid_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
